rf_write_arb: RTL and testbench

Round-robin write-port arbiter for the multi-ported register file. Up to REQ requesters share the file's WRITE write ports. Each cycle it grants up to WRITE requests with distinct addresses and drives the file's waddr/we_/wdata ports from registers one cycle later. It sits directly in front of the register file and is its only write-side driver.

---
 rtl/rf_write_arb.sv | 110 +++++++++++
 tb/tb_rf_write_arb.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/rf_write_arb.sv
// Round-robin write-port arbiter in front of a multi-ported register file.
// Grants up to WRITE distinct-address requests per cycle and registers them onto the file's ports.
module rf_write_arb #(
  parameter int DATA     = 32,
  parameter int ADDR     = 4,
  parameter int WRITE    = 4,
  parameter int REQ      = 8,
  parameter bit ZERO_REG = 1'b0
) (
  input  logic                        clk,
  input  logic                        reset_,
  input  logic [REQ-1:0]              req_,
  input  logic [REQ-1:0][ADDR-1:0]    req_addr,
  input  logic [REQ-1:0][DATA-1:0]    req_data,
  output logic [REQ-1:0]              gnt_,
  output logic [WRITE-1:0][ADDR-1:0]  waddr,
  output logic [WRITE-1:0]            we_,
  output logic [WRITE-1:0][DATA-1:0]  wdata
);

  localparam int PW = (REQ > 1) ? $clog2(REQ) : 1;

  logic [PW-1:0]                 ptr_q, ptr_d;
  logic [WRITE-1:0][ADDR-1:0]    waddr_q, waddr_d;
  logic [WRITE-1:0]              we_q, we_d;
  logic [WRITE-1:0][DATA-1:0]    wdata_q, wdata_d;

  // Requests rotated into scan order: position j is requester (ptr + j) mod REQ.
  logic [REQ-1:0][PW-1:0]        scan_idx;
  logic [REQ-1:0]                scan_req;
  logic [REQ-1:0][ADDR-1:0]      scan_addr;
  logic [REQ-1:0][DATA-1:0]      scan_data;

  generate
    for (genvar gi = 0; gi < REQ; gi++) begin : g_scan
      logic [PW:0] sum_w;
      assign sum_w         = {1'b0, ptr_q} + (PW+1)'(gi);
      assign scan_idx[gi]  = (sum_w >= (PW+1)'(REQ)) ? PW'(sum_w - (PW+1)'(REQ)) : PW'(sum_w);
      assign scan_req[gi]  = ~req_[scan_idx[gi]];
      assign scan_addr[gi] = req_addr[scan_idx[gi]];
      assign scan_data[gi] = req_data[scan_idx[gi]];
    end
  endgenerate

  logic [REQ-1:0]  sel_scan;
  logic [REQ-1:0]  sel;
  logic            conflict;
  logic            any_sel;
  logic [PW-1:0]   last_idx;
  int              cnt;

  always_comb begin
    sel_scan = '0;
    sel      = '0;
    conflict = 1'b0;
    any_sel  = 1'b0;
    last_idx = ptr_q;
    cnt      = 0;
    waddr_d  = waddr_q;
    wdata_d  = wdata_q;
    we_d     = '1;
    for (int j = 0; j < REQ; j++) begin
      if (scan_req[j] && (cnt < WRITE)) begin
        conflict = 1'b0;
        for (int j2 = 0; j2 < REQ; j2++) begin
          if ((j2 < j) && sel_scan[j2] && (scan_addr[j2] == scan_addr[j])) conflict = 1'b1;
        end
        if (!conflict) begin
          sel_scan[j]       = 1'b1;
          sel[scan_idx[j]]  = 1'b1;
          any_sel           = 1'b1;
          last_idx          = scan_idx[j];
          for (int k = 0; k < WRITE; k++) begin
            if (k == cnt) begin
              waddr_d[k] = scan_addr[j];
              wdata_d[k] = scan_data[j];
              // A granted write to register 0 still claims its port but is never issued.
              we_d[k]    = ZERO_REG && (scan_addr[j] == '0);
            end
          end
          cnt = cnt + 1;
        end
      end
    end
    if (!any_sel)                      ptr_d = ptr_q;
    else if (last_idx == PW'(REQ - 1)) ptr_d = '0;
    else                               ptr_d = last_idx + PW'(1);
  end

  assign gnt_ = reset_ ? ~sel : '1;

  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      ptr_q   <= '0;
      we_q    <= '1;
      waddr_q <= '0;
      wdata_q <= '0;
    end else begin
      ptr_q   <= ptr_d;
      we_q    <= we_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
    end
  end

  assign waddr = waddr_q;
  assign we_   = we_q;
  assign wdata = wdata_q;

endmodule

// File: tb/tb_rf_write_arb.sv
// Bench for rf_write_arb: table-driven arbitration vectors, random fairness run, mid-stream reset.
// A small register-file model sits on the write ports so write ordering can be observed.
module tb_rf_write_arb;

  localparam int DATA = 32, ADDR = 4, WRITE = 4, REQ = 8;

  logic                        clk = 1'b0;
  logic                        reset_;
  logic [REQ-1:0]              req_n;
  logic [REQ-1:0][ADDR-1:0]    req_addr;
  logic [REQ-1:0][DATA-1:0]    req_data;
  logic [REQ-1:0]              gnt_n;
  logic [WRITE-1:0][ADDR-1:0]  waddr;
  logic [WRITE-1:0]            we_n;
  logic [WRITE-1:0][DATA-1:0]  wdata;

  always #5 clk = ~clk;

  rf_write_arb #(.DATA(DATA), .ADDR(ADDR), .WRITE(WRITE), .REQ(REQ), .ZERO_REG(1'b1)) dut (
    .clk(clk), .reset_(reset_), .req_(req_n), .req_addr(req_addr), .req_data(req_data),
    .gnt_(gnt_n), .waddr(waddr), .we_(we_n), .wdata(wdata)
  );

  logic [DATA-1:0] rf [1<<ADDR];
  always @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      for (int i = 0; i < (1<<ADDR); i++) rf[i] <= '0;
    end else begin
      for (int k = 0; k < WRITE; k++) if (!we_n[k]) rf[waddr[k]] <= wdata[k];
    end
  end

  typedef struct {
    logic [REQ-1:0]            new_req;
    logic [REQ-1:0][ADDR-1:0]  addr;
    logic [REQ-1:0]            gnt_n;
    logic [WRITE-1:0]          we_n;
    int                        port_req[WRITE];
  } vec_t;

  typedef struct {
    logic [WRITE-1:0]            we_n;
    logic [WRITE-1:0][ADDR-1:0]  waddr;
    logic [WRITE-1:0][DATA-1:0]  wdata;
  } exp_t;

  exp_t exp_q[$];
  vec_t vecs[12];

  int n_checks = 0;
  int n_fail   = 0;

  logic [REQ-1:0]              pend;
  logic [REQ-1:0][ADDR-1:0]    cur_addr;
  logic [REQ-1:0][DATA-1:0]    cur_data;
  logic [WRITE-1:0][ADDR-1:0]  prev_waddr;
  logic [WRITE-1:0][DATA-1:0]  prev_wdata;
  logic [REQ-1:0]              gs;
  int                          waitc[REQ];
  int                          ngrant[REQ];

  function automatic vec_t mk(logic [7:0] nr, logic [31:0] a, logic [7:0] g, logic [3:0] w,
                              int p0, int p1, int p2, int p3);
    vec_t v;
    v.new_req = nr;
    v.addr    = a;
    v.gnt_n   = g;
    v.we_n    = w;
    v.port_req[0] = p0; v.port_req[1] = p1; v.port_req[2] = p2; v.port_req[3] = p3;
    return v;
  endfunction

  function automatic logic [DATA-1:0] dfun(int i, logic [ADDR-1:0] a);
    if (a == '0) return 32'hDEADBEEF;
    return 32'hDA7A0000 | (32'(i) << 8) | 32'(a);
  endfunction

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive();
    req_n    = ~pend;
    req_addr = cur_addr;
    req_data = cur_data;
  endtask

  task automatic run_vec(int vi);
    vec_t v;
    exp_t e, got;
    v = vecs[vi];
    @(negedge clk);
    if (vi == 0) reset_ = 1'b1;
    for (int i = 0; i < REQ; i++) begin
      if (v.new_req[i]) begin
        pend[i]     = 1'b1;
        cur_addr[i] = v.addr[i];
        cur_data[i] = dfun(i, v.addr[i]);
      end
    end
    drive();
    #1;
    gs = gnt_n;
    check($sformatf("vec%0d gnt_", vi), 64'(gnt_n), 64'(v.gnt_n));
    for (int k = 0; k < WRITE; k++) begin
      if (v.port_req[k] >= 0) begin
        prev_waddr[k] = cur_addr[v.port_req[k]];
        prev_wdata[k] = cur_data[v.port_req[k]];
      end
    end
    e.we_n  = v.we_n;
    e.waddr = prev_waddr;
    e.wdata = prev_wdata;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    pend = pend & gs;
    got = exp_q.pop_front();
    check($sformatf("vec%0d we_", vi), 64'(we_n), 64'(got.we_n));
    check($sformatf("vec%0d waddr", vi), 64'(waddr), 64'(got.waddr));
    for (int k = 0; k < WRITE; k++)
      check($sformatf("vec%0d wdata[%0d]", vi, k), 64'(wdata[k]), 64'(got.wdata[k]));
    $display("vec%0d: req_=%h gnt_=%h we_=%h waddr=%h", vi, req_n, gs, we_n, waddr);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int maxw;
    vecs[0]  = mk(8'hFF, 32'h87654321, 8'hF0, 4'h0,  0,  1,  2,  3);
    vecs[1]  = mk(8'h00, 32'h0,        8'h0F, 4'h0,  4,  5,  6,  7);
    vecs[2]  = mk(8'h00, 32'h0,        8'hFF, 4'hF, -1, -1, -1, -1);
    vecs[3]  = mk(8'h22, 32'h00300030, 8'hFD, 4'hE,  1, -1, -1, -1);
    vecs[4]  = mk(8'h00, 32'h0,        8'hDF, 4'hE,  5, -1, -1, -1);
    vecs[5]  = mk(8'h03, 32'h00000050, 8'hFC, 4'hD,  0,  1, -1, -1);
    vecs[6]  = mk(8'hFF, 32'hFEDCBA98, 8'hC3, 4'h0,  2,  3,  4,  5);
    vecs[7]  = mk(8'h00, 32'h0,        8'h3C, 4'h0,  6,  7,  0,  1);
    vecs[8]  = mk(8'h5C, 32'h0A099900, 8'hBB, 4'hC,  2,  6, -1, -1);
    vecs[9]  = mk(8'h00, 32'h0,        8'hF7, 4'hE,  3, -1, -1, -1);
    vecs[10] = mk(8'h00, 32'h0,        8'hEF, 4'hE,  4, -1, -1, -1);
    vecs[11] = mk(8'h00, 32'h0,        8'hFF, 4'hF, -1, -1, -1, -1);

    reset_     = 1'b0;
    pend       = '0;
    cur_addr   = '0;
    cur_data   = '0;
    prev_waddr = '0;
    prev_wdata = '0;
    for (int i = 0; i < REQ; i++) begin
      pend[i]     = 1'b1;
      cur_addr[i] = vecs[0].addr[i];
      cur_data[i] = dfun(i, vecs[0].addr[i]);
    end
    drive();
    repeat (2) @(negedge clk);
    #1;
    check("reset gnt_", 64'(gnt_n), 64'hFF);
    check("reset we_", 64'(we_n), 64'hF);
    check("reset waddr", 64'(waddr), 64'h0);
    check("reset wdata", 64'(wdata), 64'h0);
    $display("reset: gnt_=%h we_=%h waddr=%h", gnt_n, we_n, waddr);

    for (int vi = 0; vi < 12; vi++) run_vec(vi);

    check("rf[3] conflict order", 64'(rf[3]), 64'(dfun(5, 4'd3)));
    check("rf[0] zero reg", 64'(rf[0]), 64'h0);
    check("rf[5] zero pair", 64'(rf[5]), 64'(dfun(1, 4'd5)));
    check("rf[9] ordering", 64'(rf[9]), 64'(dfun(4, 4'd9)));
    check("rf[10]", 64'(rf[10]), 64'(dfun(6, 4'd10)));
    $display("rf: r0=%h r3=%h r5=%h r9=%h", rf[0], rf[3], rf[5], rf[9]);

    for (int i = 0; i < REQ; i++) begin waitc[i] = 0; ngrant[i] = 0; end
    for (int cyc = 0; cyc < 1000; cyc++) begin
      @(negedge clk);
      for (int i = 0; i < REQ; i++) begin
        if (!pend[i] && (i == 2 || $urandom_range(1) == 1)) begin
          pend[i]     = 1'b1;
          cur_addr[i] = ADDR'(i + 1);
          cur_data[i] = $urandom;
        end
      end
      drive();
      #1;
      gs   = gnt_n;
      maxw = 0;
      for (int i = 0; i < REQ; i++) begin
        if (pend[i]) begin
          waitc[i]++;
          if (waitc[i] > maxw) maxw = waitc[i];
          if (!gs[i]) begin
            if (i == 2) check("fair req2 wait<=REQ", 64'(waitc[i] <= REQ), 64'h1);
            ngrant[i]++;
            waitc[i] = 0;
          end
        end
      end
      check("starve max wait<=REQ", 64'(maxw <= REQ), 64'h1);
      @(posedge clk);
      pend = pend & gs;
    end
    for (int i = 0; i < REQ; i++)
      check($sformatf("granted req%0d", i), 64'(ngrant[i] > 0), 64'h1);
    $display("fairness: grants %0d %0d %0d %0d %0d %0d %0d %0d", ngrant[0], ngrant[1],
             ngrant[2], ngrant[3], ngrant[4], ngrant[5], ngrant[6], ngrant[7]);

    for (int c = 0; c < 20 && pend != '0; c++) begin
      @(negedge clk);
      drive();
      #1;
      gs = gnt_n;
      @(posedge clk);
      pend = pend & gs;
    end
    check("drain", 64'(pend), 64'h0);

    @(negedge clk);
    pend        = 8'h08;
    cur_addr[3] = 4'd12;
    cur_data[3] = dfun(3, 4'd12);
    drive();
    #1;
    check("midrst gnt_", 64'(gnt_n), 64'hF7);
    @(posedge clk);
    #1;
    check("midrst we_ before", 64'(we_n), 64'hE);
    pend   = '1;
    drive();
    reset_ = 1'b0;
    #1;
    check("midrst we_ dropped", 64'(we_n), 64'hF);
    check("midrst waddr", 64'(waddr), 64'h0);
    check("midrst gnt_ held", 64'(gnt_n), 64'hFF);
    @(negedge clk);
    pend = '0;
    drive();
    reset_ = 1'b1;
    @(posedge clk);
    #1;
    check("midrst rf[12]", 64'(rf[12]), 64'h0);
    check("midrst idle we_", 64'(we_n), 64'hF);
    $display("midrst: we_=%h rf[12]=%h", we_n, rf[12]);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
